// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control sequencer: FETCH -> EXECUTE -> (MEM) over one shared memory port.
// Optional misalignment trap enabled by defining CTRL_MISALIGN_TRAP_EN.
module multicycle_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      action_type,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [2:0]      mem_func3,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  output logic            reg_wen,
  output logic            halted,
  output logic            trap
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    MEM     = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [2:0] ACT_STORE  = 3'd1;
  localparam logic [2:0] ACT_LOAD   = 3'd2;
  localparam logic [2:0] ACT_BRANCH = 3'd3;
  localparam logic [2:0] ACT_JAL    = 3'd4;
  localparam logic [2:0] ACT_SYSTEM = 3'd5;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] dataAddr;
  logic            isStore, isLoad;

  assign dataAddr    = rs1_data + immediate;
  assign isStore     = (action_type == ACT_STORE);
  assign isLoad      = (action_type == ACT_LOAD);
  assign pc          = pc_q;
  assign instruction = instr_q;

`ifdef CTRL_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic dataMisaligned, targetMisaligned;

  // Word needs addr[1:0]==0, halfword needs addr[0]==0; byte and func3[1:0]=11 never trap.
  always_comb begin
    dataMisaligned = 1'b0;
    case (func3[1:0])
      2'b01:   dataMisaligned = dataAddr[0];
      2'b10:   dataMisaligned = |dataAddr[1:0];
      default: dataMisaligned = 1'b0;
    endcase
    targetMisaligned = |pc_next[1:0];
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef CTRL_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef CTRL_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
`ifdef CTRL_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    mem_req   = 1'b0;
    mem_addr  = pc_q;
    mem_wen   = 1'b0;
    mem_func3 = 3'b010;
    reg_wen   = 1'b0;
    halted    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = EXECUTE;
        end
      end

      EXECUTE: begin
        case (action_type)
          ACT_STORE, ACT_LOAD: begin
            state_d = MEM;
`ifdef CTRL_MISALIGN_TRAP_EN
            if (dataMisaligned) begin
              state_d = HALT;
              trap_d  = 1'b1;
            end
`endif
          end
          ACT_BRANCH: begin
            pc_d    = pc_next;
            state_d = FETCH;
`ifdef CTRL_MISALIGN_TRAP_EN
            if (targetMisaligned) begin
              pc_d    = pc_q;
              state_d = HALT;
              trap_d  = 1'b1;
            end
`endif
          end
          ACT_JAL: begin
            reg_wen = 1'b1;
            pc_d    = pc_next;
            state_d = FETCH;
`ifdef CTRL_MISALIGN_TRAP_EN
            if (targetMisaligned) begin
              reg_wen = 1'b0;
              pc_d    = pc_q;
              state_d = HALT;
              trap_d  = 1'b1;
            end
`endif
          end
          ACT_SYSTEM: begin
            state_d = HALT;
          end
          default: begin
            reg_wen = 1'b1;
            pc_d    = pc_next;
            state_d = FETCH;
          end
        endcase
      end

      MEM: begin
        mem_req   = 1'b1;
        mem_addr  = dataAddr;
        mem_func3 = func3;
        mem_wen   = isStore;
        if (mem_ready) begin
          reg_wen = isLoad;
          pc_d    = pc_next;
          state_d = FETCH;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset kills any in-flight request and strobe immediately, before the clock edge.
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_wen = 1'b0;
      reg_wen = 1'b0;
      halted  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (RESET_PC=0x100, XLEN=32).
// Build with CTRL_MISALIGN_TRAP_EN defined to exercise the trap path.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  action_type;
  logic [2:0]  func3;
  logic [31:0] rs1_data;
  logic [31:0] immediate;
  logic [31:0] pc_next;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [2:0]  mem_func3;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        reg_wen;
  logic        halted;
  logic        trap;

  int checks;
  int failures;

  multicycle_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .action_type(action_type),
    .func3      (func3),
    .rs1_data   (rs1_data),
    .immediate  (immediate),
    .pc_next    (pc_next),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_func3  (mem_func3),
    .pc         (pc),
    .instruction(instruction),
    .reg_wen    (reg_wen),
    .halted     (halted),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic rstN, input logic ready, input logic [31:0] rdata,
                               input logic [2:0] act, input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [31:0] imm, input logic [31:0] pcNext);
    @(negedge clk);
    rst_n       = rstN;
    mem_ready   = ready;
    mem_rdata   = rdata;
    action_type = act;
    func3       = f3;
    rs1_data    = rs1;
    immediate   = imm;
    pc_next     = pcNext;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset
    applyStimulus(1'b0, 1'b1, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("rst_pc", pc, 32'h100);
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_reg_wen", {31'h0, reg_wen}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted}, 32'h0);
    checkOutput("rst_trap", {31'h0, trap}, 32'h0);

    // ALU with zero-wait fetch
    applyStimulus(1'b1, 1'b1, 32'h0000_0013, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("f0_req", {31'h0, mem_req}, 32'h1);
    checkOutput("f0_addr", mem_addr, 32'h100);
    checkOutput("f0_func3", {29'h0, mem_func3}, 32'h2);
    checkOutput("f0_wen", {31'h0, mem_wen}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h104);
    checkOutput("alu_instr", instruction, 32'h0000_0013);
    checkOutput("alu_req", {31'h0, mem_req}, 32'h0);
    checkOutput("alu_reg_wen", {31'h0, reg_wen}, 32'h1);

    // LOAD with wrapping address and three wait states
    applyStimulus(1'b1, 1'b1, 32'h0000_2003, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("ld_fetch_pc", pc, 32'h104);
    checkOutput("ld_fetch_addr", mem_addr, 32'h104);
    checkOutput("ld_fetch_reg_wen", {31'h0, reg_wen}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h108);
    checkOutput("ld_exec_req", {31'h0, mem_req}, 32'h0);
    checkOutput("ld_exec_reg_wen", {31'h0, reg_wen}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h108);
      checkOutput("ld_wait_req", {31'h0, mem_req}, 32'h1);
      checkOutput("ld_wait_addr", mem_addr, 32'h4);
      checkOutput("ld_wait_wen", {31'h0, mem_wen}, 32'h0);
      checkOutput("ld_wait_reg_wen", {31'h0, reg_wen}, 32'h0);
      checkOutput("ld_wait_pc", pc, 32'h104);
    end
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 3'd2, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h108);
    checkOutput("ld_rdy_addr", mem_addr, 32'h4);
    checkOutput("ld_rdy_func3", {29'h0, mem_func3}, 32'h2);
    checkOutput("ld_rdy_reg_wen", {31'h0, reg_wen}, 32'h1);

    // STORE byte
    applyStimulus(1'b1, 1'b1, 32'h0000_0023, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("st_fetch_pc", pc, 32'h108);
    checkOutput("st_fetch_addr", mem_addr, 32'h108);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd1, 3'b000, 32'h200, 32'h10, 32'h10C);
    checkOutput("st_exec_wen", {31'h0, mem_wen}, 32'h0);
    checkOutput("st_exec_reg_wen", {31'h0, reg_wen}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0, 3'd1, 3'b000, 32'h200, 32'h10, 32'h10C);
    checkOutput("st_mem_req", {31'h0, mem_req}, 32'h1);
    checkOutput("st_mem_wen", {31'h0, mem_wen}, 32'h1);
    checkOutput("st_mem_addr", mem_addr, 32'h210);
    checkOutput("st_mem_func3", {29'h0, mem_func3}, 32'h0);
    checkOutput("st_mem_reg_wen", {31'h0, reg_wen}, 32'h0);

    // BRANCH to 0x40
    applyStimulus(1'b1, 1'b1, 32'h0000_0063, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("br_fetch_pc", pc, 32'h10C);
    checkOutput("br_fetch_wen", {31'h0, mem_wen}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd3, 3'd0, 32'h0, 32'h0, 32'h40);
    checkOutput("br_reg_wen", {31'h0, reg_wen}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0033, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("br_target_addr", mem_addr, 32'h40);

    // Action 7 aliases ALU, then JAL
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd7, 3'd0, 32'h0, 32'h0, 32'h44);
    checkOutput("alias_reg_wen", {31'h0, reg_wen}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h0000_006F, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("jal_fetch_addr", mem_addr, 32'h44);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd4, 3'd0, 32'h0, 32'h0, 32'h80);
    checkOutput("jal_reg_wen", {31'h0, reg_wen}, 32'h1);

    // SYSTEM halts, sticky for 20 cycles
    applyStimulus(1'b1, 1'b1, 32'h0000_0073, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("sys_fetch_addr", mem_addr, 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd5, 3'd0, 32'h0, 32'h0, 32'h84);
    checkOutput("sys_reg_wen", {31'h0, reg_wen}, 32'h0);
    checkOutput("sys_req", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h84);
      checkOutput("halt_flag", {31'h0, halted}, 32'h1);
      checkOutput("halt_req", {31'h0, mem_req}, 32'h0);
      checkOutput("halt_reg_wen", {31'h0, reg_wen}, 32'h0);
    end
    checkOutput("halt_pc", pc, 32'h80);
    checkOutput("halt_trap", {31'h0, trap}, 32'h0);

    // Reset out of HALT
    applyStimulus(1'b0, 1'b1, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("hrst_halted", {31'h0, halted}, 32'h0);
    checkOutput("hrst_req", {31'h0, mem_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("hrst_pc", pc, 32'h100);
    checkOutput("hrst_addr", mem_addr, 32'h100);
    checkOutput("hrst_fetch_req", {31'h0, mem_req}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h0000_2083, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("hrst_wait_addr", mem_addr, 32'h100);

    // Reset during a MEM wait
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'h300, 32'h4, 32'h104);
    checkOutput("mrst_exec_instr", instruction, 32'h0000_2083);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'h300, 32'h4, 32'h104);
    checkOutput("mrst_mem_req", {31'h0, mem_req}, 32'h1);
    checkOutput("mrst_mem_addr", mem_addr, 32'h304);
    applyStimulus(1'b0, 1'b1, 32'h0, 3'd2, 3'b010, 32'h300, 32'h4, 32'h104);
    checkOutput("mrst_req_drop", {31'h0, mem_req}, 32'h0);
    checkOutput("mrst_reg_wen", {31'h0, reg_wen}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2103, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("mrst_pc", pc, 32'h100);
    checkOutput("mrst_refetch", mem_addr, 32'h100);
    checkOutput("mrst_instr", instruction, 32'h0);

    // Misaligned word LOAD at address 0x2
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'h0, 32'h2, 32'h104);
    checkOutput("mis_exec_reg_wen", {31'h0, reg_wen}, 32'h0);
    checkOutput("mis_exec_req", {31'h0, mem_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd2, 3'b010, 32'h0, 32'h2, 32'h104);
`ifdef CTRL_MISALIGN_TRAP_EN
    checkOutput("mis_trap", {31'h0, trap}, 32'h1);
    checkOutput("mis_halted", {31'h0, halted}, 32'h1);
    checkOutput("mis_req", {31'h0, mem_req}, 32'h0);
    checkOutput("mis_pc", pc, 32'h100);
`else
    checkOutput("mis_trap", {31'h0, trap}, 32'h0);
    checkOutput("mis_halted", {31'h0, halted}, 32'h0);
    checkOutput("mis_req", {31'h0, mem_req}, 32'h1);
    checkOutput("mis_addr", mem_addr, 32'h2);
    applyStimulus(1'b1, 1'b1, 32'h0, 3'd2, 3'b010, 32'h0, 32'h2, 32'h104);
    checkOutput("mis_reg_wen", {31'h0, reg_wen}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("mis_pc", pc, 32'h104);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
